// File: rtl/spatz_result_buffer_pkg.sv
// rtl/spatz_result_buffer_pkg.sv - shared result-channel types and default sizes for the Spatz result buffer
package spatz_result_buffer_pkg;

  localparam int unsigned ResultBufDepth  = 4;
  localparam int unsigned ResultIdWidth   = 4;
  localparam int unsigned ResultDataWidth = 32;

  typedef struct packed {
    logic [ResultIdWidth-1:0]   id;
    logic [4:0]                 rd;
    logic [ResultDataWidth-1:0] data;
    logic                       we;
  } spatz_result_t;

endpackage

// File: rtl/spatz_result_buffer.sv
// rtl/spatz_result_buffer.sv - in-order decoupling FIFO on the X-interface result channel
// with optional fall-through when empty.
module spatz_result_buffer
  import spatz_result_buffer_pkg::*;
#(
  parameter int unsigned Depth       = ResultBufDepth,
  parameter int unsigned DataWidth   = ResultDataWidth,
  parameter int unsigned IdWidth     = ResultIdWidth,
  parameter int unsigned FallThrough = 1,
  parameter int unsigned AlmostFull  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [IdWidth-1:0]         in_id_i,
  input  logic [4:0]                 in_rd_i,
  input  logic [DataWidth-1:0]       in_data_i,
  input  logic                       in_we_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [IdWidth-1:0]         out_id_o,
  output logic [4:0]                 out_rd_o,
  output logic [DataWidth-1:0]       out_data_o,
  output logic                       out_we_o,
  output logic [$clog2(Depth):0]     usage_o,
  output logic                       almost_full_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned UW = AW + 1;
  localparam int unsigned PW = IdWidth + 5 + DataWidth + 1;

  logic [PW-1:0] r_mem [Depth];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [UW-1:0] r_usage;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass;
  logic          w_write;
  logic          w_read;
  logic          w_out_valid;
  logic [PW-1:0] w_in_word;
  logic [PW-1:0] w_out_word;
  logic [UW-1:0] w_free;

  assign w_in_word = {in_id_i, in_rd_i, in_data_i, in_we_i};
  assign w_full    = (r_usage == UW'(Depth));
  assign w_empty   = (r_usage == '0);

  // Ready is forced high in reset so the reset state is well defined before the counters settle.
  assign in_ready_o = rst_i | ~w_full;
  assign w_push     = in_valid_i & in_ready_o;

  always_comb begin
    w_out_valid = 1'b0;
    w_out_word  = '0;
    if (!w_empty) begin
      w_out_valid = 1'b1;
      w_out_word  = r_mem[r_rd_ptr];
    end else if (FallThrough != 0 && in_valid_i) begin
      w_out_valid = 1'b1;
      w_out_word  = w_in_word;
    end
    if (rst_i) begin
      w_out_valid = 1'b0;
    end
  end

  assign out_valid_o = w_out_valid;
  assign {out_id_o, out_rd_o, out_data_o, out_we_o} = w_out_word;
  assign w_pop = w_out_valid & out_ready_i;

  // A pop while empty can only be the fall-through entry, which never touches storage.
  assign w_bypass = w_empty & w_pop;
  assign w_write  = w_push & ~w_bypass;
  assign w_read   = w_pop & ~w_bypass;

  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_in_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_read)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_usage <= r_usage + UW'(w_write) - UW'(w_read);
    end
  end

  assign w_free        = UW'(Depth) - r_usage;
  assign almost_full_o = (w_free <= UW'(AlmostFull));
  assign usage_o       = r_usage;

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
    $error("Depth must be a power of two and at least 2");
  end
  if (AlmostFull >= Depth) begin : g_bad_almost_full
    $error("AlmostFull must be below Depth");
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_full));
  a_usage_bound:  assert property (@(posedge clk_i) disable iff (rst_i) r_usage <= UW'(Depth));
  a_out_stable:   assert property (@(posedge clk_i) disable iff (rst_i)
                    (w_out_valid && !out_ready_i && !flush_i) |=> (w_out_valid && $stable(w_out_word)));

endmodule

// File: tb/tb_spatz_result_buffer.sv
// tb/tb_spatz_result_buffer.sv - self-checking bench for spatz_result_buffer (fall-through and registered variants)
module tb_spatz_result_buffer;
  import spatz_result_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, in_we, out_valid, out_ready, out_we, almost_full;
  logic [3:0]  in_id, out_id;
  logic [4:0]  in_rd, out_rd;
  logic [31:0] in_data, out_data;
  logic [2:0]  usage;

  logic        nf_flush;
  logic        nf_in_valid, nf_in_ready, nf_out_valid, nf_out_ready, nf_out_we, nf_almost_full;
  logic [3:0]  nf_out_id;
  logic [4:0]  nf_out_rd;
  logic [31:0] nf_out_data;
  logic [2:0]  nf_usage;

  int checks = 0;
  int errors = 0;
  spatz_result_t q[$];

  always #5 clk = ~clk;

  spatz_result_buffer #(.Depth(4), .DataWidth(32), .IdWidth(4), .FallThrough(1), .AlmostFull(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_id_i(in_id), .in_rd_i(in_rd),
    .in_data_i(in_data), .in_we_i(in_we),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_id_o(out_id), .out_rd_o(out_rd),
    .out_data_o(out_data), .out_we_o(out_we), .usage_o(usage), .almost_full_o(almost_full)
  );

  spatz_result_buffer #(.Depth(4), .DataWidth(32), .IdWidth(4), .FallThrough(0), .AlmostFull(1)) dut_nf (
    .clk_i(clk), .rst_i(rst), .flush_i(nf_flush),
    .in_valid_i(nf_in_valid), .in_ready_o(nf_in_ready), .in_id_i(in_id), .in_rd_i(in_rd),
    .in_data_i(in_data), .in_we_i(in_we),
    .out_valid_o(nf_out_valid), .out_ready_i(nf_out_ready), .out_id_o(nf_out_id), .out_rd_o(nf_out_rd),
    .out_data_o(nf_out_data), .out_we_o(nf_out_we), .usage_o(nf_usage), .almost_full_o(nf_almost_full)
  );

  // Queue-level view of the buffer: a flush/reset empties it, otherwise push appends and pop takes the head.
  task automatic model_edge(input logic push, input logic pop, input logic fl, input spatz_result_t w);
    if (fl) begin
      q.delete();
    end else begin
      if (push) q.push_back(w);
      if (pop)  void'(q.pop_front());
    end
  endtask

  task automatic drive_payload(input logic [3:0] id, input logic [31:0] data);
    in_id   = id;
    in_rd   = 5'($urandom_range(0, 31));
    in_data = data;
    in_we   = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    nf_in_valid = 1'b0; nf_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    nf_in_valid = 1'b1; nf_out_ready = 1'b1;
    drive_payload(4'h3, 32'h1234_5678);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (usage !== 3'd0) begin errors++; $display("FAIL reset_usage: got %0d expected 0", usage); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (nf_out_valid !== 1'b0 || nf_usage !== 3'd0) begin errors++; $display("FAIL reset_nf: got valid %b usage %0d expected 0 0", nf_out_valid, nf_usage); end
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; nf_in_valid = 1'b0; nf_out_ready = 1'b0;
    @(negedge clk);
    checks++; if (almost_full !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got af %b valid %b expected 0 0", almost_full, out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    spatz_result_t saved[4];
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      drive_payload(4'(i), $urandom);
      saved[i-1] = {in_id, in_rd, in_data, in_we};
      @(negedge clk);
      checks++; if (usage !== 3'(i-1)) begin errors++; $display("FAIL fill_usage: got %0d expected %0d", usage, i-1); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready: got %b expected 1", in_ready); end
      checks++; if (almost_full !== (i-1 >= 3)) begin errors++; $display("FAIL fill_almost_full: got %b expected %b at usage %0d", almost_full, (i-1 >= 3), i-1); end
      model_edge(1'b1, 1'b0, 1'b0, saved[i-1]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (usage !== 3'd4 || in_ready !== 1'b0 || almost_full !== 1'b1) begin errors++; $display("FAIL fill_full: got usage %0d ready %b af %b expected 4 0 1", usage, in_ready, almost_full); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_id !== 4'(i)) begin errors++; $display("FAIL drain_order: got valid %b id %0d expected 1 %0d", out_valid, out_id, i); end
      checks++; if ({out_id, out_rd, out_data, out_we} !== saved[i-1]) begin errors++; $display("FAIL drain_payload: got %h expected %h", {out_id, out_rd, out_data, out_we}, saved[i-1]); end
      model_edge(1'b0, 1'b1, 1'b0, saved[i-1]);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (usage !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got usage %0d valid %b expected 0 0", usage, out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_fall_through();
    logic [31:0] held;
    in_valid = 1'b1; nf_in_valid = 1'b1; out_ready = 1'b1; nf_out_ready = 1'b1;
    drive_payload(4'd7, 32'h0000_CAFE);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_CAFE || out_id !== 4'd7) begin errors++; $display("FAIL ft_same_cycle: got valid %b id %0d data %h expected 1 7 cafe", out_valid, out_id, out_data); end
    checks++; if (nf_out_valid !== 1'b0) begin errors++; $display("FAIL nf_no_bypass: got %b expected 0", nf_out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0; nf_in_valid = 1'b0;
    drive_payload(4'd0, 32'h0);
    @(negedge clk);
    checks++; if (usage !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL ft_bypass_usage: got usage %0d valid %b expected 0 0", usage, out_valid); end
    checks++; if (nf_out_valid !== 1'b1 || nf_out_data !== 32'h0000_CAFE || nf_out_id !== 4'd7 || nf_usage !== 3'd1) begin errors++; $display("FAIL nf_next_cycle: got valid %b id %0d data %h usage %0d expected 1 7 cafe 1", nf_out_valid, nf_out_id, nf_out_data, nf_usage); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (nf_usage !== 3'd0 || nf_out_valid !== 1'b0) begin errors++; $display("FAIL nf_popped: got usage %0d valid %b expected 0 0", nf_usage, nf_out_valid); end
    @(posedge clk); #1;
    nf_out_ready = 1'b0;
    // Fall-through offer not accepted: the entry must be captured and held.
    out_ready = 1'b0; in_valid = 1'b1;
    held = $urandom;
    drive_payload(4'd5, held);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_id !== 4'd5) begin errors++; $display("FAIL ft_offer: got valid %b id %0d expected 1 5", out_valid, out_id); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive_payload(4'd0, 32'h0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_id !== 4'd5 || out_data !== held || usage !== 3'd1) begin errors++; $display("FAIL ft_held: got valid %b id %0d data %h usage %0d expected 1 5 %h 1", out_valid, out_id, out_data, usage, held); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (usage !== 3'd0) begin errors++; $display("FAIL ft_held_pop: got usage %0d expected 0", usage); end
    @(posedge clk); #1;
    q.delete();
  endtask

  task automatic test_back_to_back();
    spatz_result_t w, o;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      drive_payload(4'(i), $urandom);
      model_edge(1'b1, 1'b0, 1'b0, {in_id, in_rd, in_data, in_we});
      @(posedge clk); #1;
    end
    for (int i = 2; i < 12; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      drive_payload(4'(i), $urandom);
      w = {in_id, in_rd, in_data, in_we};
      @(negedge clk);
      o = {out_id, out_rd, out_data, out_we};
      checks++; if (usage !== 3'd2 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_usage: got usage %0d ready %b expected 2 1", usage, in_ready); end
      checks++; if (out_valid !== 1'b1 || o !== q[0]) begin errors++; $display("FAIL b2b_order: got valid %b word %h expected 1 %h", out_valid, o, q[0]); end
      model_edge(1'b1, 1'b1, 1'b0, w);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = {out_id, out_rd, out_data, out_we};
      checks++; if (out_valid !== 1'b1 || o !== q[0]) begin errors++; $display("FAIL b2b_drain: got valid %b word %h expected 1 %h", out_valid, o, q[0]); end
      model_edge(1'b0, 1'b1, 1'b0, o);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      drive_payload(4'(i), $urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; flush = 1'b1;
    drive_payload(4'd9, 32'h9999_9999);
    @(negedge clk);
    checks++; if (usage !== 3'd3) begin errors++; $display("FAIL flush_pre_usage: got %0d expected 3", usage); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (usage !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_cleared: got usage %0d valid %b id %0d expected 0 0", usage, out_valid, out_id); end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    q.delete();
  endtask

  task automatic test_random();
    int pops = 0;
    int cycles = 0;
    int sz;
    logic exp_ready, exp_valid, exp_af, push, pop;
    spatz_result_t w, o, head;
    while (pops < 10000 && cycles < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 499) == 0);
      drive_payload(4'($urandom_range(0, 15)), $urandom);
      w = {in_id, in_rd, in_data, in_we};
      @(negedge clk);
      sz        = q.size();
      exp_ready = (sz < DEPTH);
      exp_valid = (sz > 0) || in_valid;
      exp_af    = ((DEPTH - sz) <= 1);
      head      = (sz > 0) ? q[0] : w;
      o         = {out_id, out_rd, out_data, out_we};
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rand_ready: cycle %0d got %b expected %b", cycles, in_ready, exp_ready); end
      checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rand_valid: cycle %0d got %b expected %b", cycles, out_valid, exp_valid); end
      checks++; if (usage !== 3'(sz)) begin errors++; $display("FAIL rand_usage: cycle %0d got %0d expected %0d", cycles, usage, sz); end
      checks++; if (almost_full !== exp_af) begin errors++; $display("FAIL rand_almost_full: cycle %0d got %b expected %b", cycles, almost_full, exp_af); end
      if (exp_valid) begin
        checks++; if (o !== head) begin errors++; $display("FAIL rand_payload: cycle %0d got %h expected %h", cycles, o, head); end
      end
      push = in_valid & exp_ready;
      pop  = exp_valid & out_ready;
      if (pop) pops++;
      model_edge(push, pop, flush, w);
      cycles++;
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (pops < 10000) begin errors++; $display("FAIL rand_budget: got %0d results expected 10000 within cycle bound", pops); end
  endtask

  initial begin
    nf_flush = 1'b0;
    in_id = '0; in_rd = '0; in_data = '0; in_we = 1'b0;
    test_reset();
    test_fill();
    test_fall_through();
    do_reset();
    test_back_to_back();
    do_reset();
    test_flush();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
